// File: rtl/pipe_arb_pkg.sv
// pipe_arb_pkg: shared types and constants for the pipe_in_arbiter slice.
//   PIPE_ARB_MAX_CLIENTS : upper bound on the number of requesters
//   client_idx_t         : encoded client index, wide enough for the maximum client count
//   stats_t              : 32-bit wrapping statistics counter
package pipe_arb_pkg;

    localparam int unsigned PIPE_ARB_MAX_CLIENTS = 16;

    typedef logic [$clog2(PIPE_ARB_MAX_CLIENTS)-1:0] client_idx_t;
    typedef logic [31:0]                             stats_t;

endpackage

// File: rtl/pipe_arb_rr_pick.sv
// pipe_arb_rr_pick: combinational round-robin picker.
// Finds the first set bit of req, scanning upward from ptr with wrap-around.
//   req   in  NUM_CLIENTS : request vector
//   ptr   in  PTR_W       : scan start position
//   grant out NUM_CLIENTS : one-hot winner, all zero when nothing requests
//   idx   out             : encoded winner (0 when nothing requests)
//   any   out 1           : some request is set
module pipe_arb_rr_pick
    import pipe_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned PTR_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [NUM_CLIENTS-1:0] grant,
    output client_idx_t            idx,
    output logic                   any
);

    // Outer loop walks the distance from ptr; inner loop keeps every bit select constant.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (!any && req[i] && (i == ((32'(ptr) + k) % NUM_CLIENTS))) begin
                    grant[i] = 1'b1;
                    idx      = client_idx_t'(i);
                    any      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_in_arbiter.sv
// pipe_in_arbiter: round-robin share of one pipe enqueue port between NUM_CLIENTS sources.
// A single-entry output register feeds the pipe; it can drain and reload in the same cycle.
//   CLK, nRST         : clock, synchronous active-low reset
//   req_valid         : client i has a word ready
//   req_enq__ENA      : client i enqueues (only while its RDY is high)
//   req_enq_v         : packed words, client i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_enq__RDY      : one-hot grant or zero; never depends on any ENA
//   pipe_enq__ENA/_v  : enqueue strobe and word towards the pipe
//   pipe_enq__RDY     : pipe can accept
//   stats_count       : per-client accepted-word counters, client i at [i*32 +: 32]
//   stats_stall       : cycles spent holding a word under backpressure
// Build option: define PIPE_ARB_STATS_EN to build the counters; otherwise stats ports read 0.
module pipe_in_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned DATA_WIDTH  = 192
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic [NUM_CLIENTS-1:0]            req_valid,
    input  logic [NUM_CLIENTS-1:0]            req_enq__ENA,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_enq_v,
    output logic [NUM_CLIENTS-1:0]            req_enq__RDY,
    output logic                              pipe_enq__ENA,
    output logic [DATA_WIDTH-1:0]             pipe_enq_v,
    input  logic                              pipe_enq__RDY,
    output logic [NUM_CLIENTS*32-1:0]         stats_count,
    output logic [31:0]                       stats_stall
);

    localparam int unsigned PTR_W = $clog2(NUM_CLIENTS);

    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [PTR_W-1:0]       rr_ptr;

    logic                   can_load;
    logic [NUM_CLIENTS-1:0] pick_grant;
    client_idx_t            pick_idx;
    logic                   pick_any;
    logic [NUM_CLIENTS-1:0] accepted;
    logic                   load;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [PTR_W-1:0]       ptr_next;

    pipe_arb_rr_pick #(
        .NUM_CLIENTS(NUM_CLIENTS),
        .PTR_W      (PTR_W)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(pick_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign can_load      = !out_valid || pipe_enq__RDY;
    assign req_enq__RDY  = (nRST && can_load) ? pick_grant : '0;
    assign pipe_enq__ENA = nRST && out_valid && pipe_enq__RDY;
    assign pipe_enq_v    = out_data;

    // Masking with RDY drops ENA from non-granted clients.
    assign accepted = req_enq__ENA & req_enq__RDY;
    assign load     = pick_any && (|accepted);

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (pick_grant[i]) sel_data = req_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        if (32'(pick_idx) == NUM_CLIENTS - 1) ptr_next = '0;
        else                                  ptr_next = PTR_W'(32'(pick_idx) + 32'd1);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            rr_ptr    <= ptr_next;
        end else if (pipe_enq__ENA) begin
            out_valid <= 1'b0;
        end
    end

    // Payload carries no reset; it is only meaningful while out_valid is set.
    always_ff @(posedge CLK) begin
        if (nRST && load) out_data <= sel_data;
    end

`ifdef PIPE_ARB_STATS_EN
    stats_t cnt_q [NUM_CLIENTS];
    stats_t stall_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) cnt_q[i] <= '0;
            stall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (accepted[i]) cnt_q[i] <= cnt_q[i] + 32'd1;
            end
            if (out_valid && !pipe_enq__RDY) stall_q <= stall_q + 32'd1;
        end
    end

    always_comb begin
        stats_count = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) stats_count[i*32 +: 32] = cnt_q[i];
    end
    assign stats_stall = stall_q;
`else
    assign stats_count = '0;
    assign stats_stall = '0;
`endif

    a_ena_needs_rdy: assert property (@(posedge CLK) disable iff (!nRST)
        ((req_enq__ENA & ~req_enq__RDY) == '0));

endmodule

// File: tb/tb_pipe_in_arbiter.sv
module tb_pipe_in_arbiter;

    localparam int N  = 4;
    localparam int DW = 192;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ena = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_rdy;
    logic              pipe_ena;
    logic [DW-1:0]     pipe_data;
    logic              pipe_rdy = 1'b0;
    logic [N*32-1:0]   stats_count;
    logic [31:0]       stats_stall;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    bit              m_valid = 1'b0;
    logic [DW-1:0]   m_data  = '0;
    int              m_ptr   = 0;
    logic [31:0]     m_cnt [N];
    logic [31:0]     m_stall = '0;

    pipe_in_arbiter #(
        .NUM_CLIENTS(N),
        .DATA_WIDTH (DW)
    ) dut (
        .CLK          (clk),
        .nRST         (nrst),
        .req_valid    (req_valid),
        .req_enq__ENA (req_ena),
        .req_enq_v    (req_data),
        .req_enq__RDY (req_rdy),
        .pipe_enq__ENA(pipe_ena),
        .pipe_enq_v   (pipe_data),
        .pipe_enq__RDY(pipe_rdy),
        .stats_count  (stats_count),
        .stats_stall  (stats_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner = valid client with the smallest forward distance from the pointer.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            int d = (i - ptr + N) % N;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    function automatic int exp_grant();
        if (!nrst || (m_valid && !pipe_rdy)) return -1;
        return pick(req_valid, m_ptr);
    endfunction

    function automatic logic [N-1:0] exp_rdy();
        logic [N-1:0] r = '0;
        int g = exp_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    initial for (int i = 0; i < N; i++) m_cnt[i] = '0;

    always @(posedge clk) begin : model_upd
        int  g;
        bit  drain;
        g     = exp_grant();
        drain = nrst && m_valid && pipe_rdy;
        if (!nrst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            m_stall = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = '0;
        end else begin
            if (m_valid && !pipe_rdy) m_stall = m_stall + 1;
            if (g >= 0 && req_ena[g]) begin
                m_data   = req_data[g*DW +: DW];
                m_valid  = 1'b1;
                m_ptr    = (g + 1) % N;
                m_cnt[g] = m_cnt[g] + 1;
            end else if (drain) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("grant_rdy", 256'(req_rdy), 256'(exp_rdy()));
            check("pipe_ena", 256'(pipe_ena), 256'(nrst && m_valid && pipe_rdy));
            if (m_valid) check("pipe_data", 256'(pipe_data), 256'(m_data));
            for (int i = 0; i < N; i++) begin
`ifdef PIPE_ARB_STATS_EN
                check("stats_count", 256'(stats_count[i*32 +: 32]), 256'(m_cnt[i]));
`else
                check("stats_count", 256'(stats_count[i*32 +: 32]), 256'(0));
`endif
            end
`ifdef PIPE_ARB_STATS_EN
            check("stats_stall", 256'(stats_stall), 256'(m_stall));
`else
            check("stats_stall", 256'(stats_stall), 256'(0));
`endif
        end
    end

    // One clock of stimulus; ENA follows the model's grant and the wanted mask.
    task automatic cycle(input logic nr, input logic [N-1:0] v, input logic [N-1:0] want,
                         input logic r, input logic [DW-1:0] d, input bit rnd);
        int g;
        @(posedge clk);
        #1;
        nrst      = nr;
        req_valid = v;
        pipe_rdy  = r;
        for (int i = 0; i < N; i++) begin
            if (rnd) begin
                for (int w = 0; w < DW / 32; w++) req_data[i*DW + w*32 +: 32] = $urandom;
            end else begin
                req_data[i*DW +: DW] = d;
            end
        end
        g       = exp_grant();
        req_ena = '0;
        if (g >= 0 && want[g]) req_ena[g] = 1'b1;
    endtask

    initial begin
        cycle(1'b0, '0, '0, 1'b1, '0, 1'b0);
        chk_en = 1'b1;
        cycle(1'b0, '0, '0, 1'b1, '0, 1'b0);

        // Single client, back-to-back words
        cycle(1'b1, 4'b0100, 4'b0100, 1'b1, 192'hA5, 1'b0);
        @(negedge clk);
        check("single_rdy", 256'(req_rdy), 256'(4'b0100));
        cycle(1'b1, 4'b0100, 4'b0100, 1'b1, 192'hA6, 1'b0);
        @(negedge clk);
        check("single_lat_ena", 256'(pipe_ena), 256'(1));
        check("single_lat_data", 256'(pipe_data), 256'(192'hA5));
        cycle(1'b1, 4'b0000, 4'b0000, 1'b1, '0, 1'b0);
        @(negedge clk);
        check("single_b2b_data", 256'(pipe_data), 256'(192'hA6));

        // All valid: round-robin order from pointer 0
        cycle(1'b0, '0, '0, 1'b1, '0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 4'hF, 4'hF, 1'b1, '0, 1'b1);
            @(negedge clk);
            check("rr_order", 256'(req_rdy), 256'(4'b0001 << (k % 4)));
        end
        cycle(1'b1, 4'h0, 4'h0, 1'b1, '0, 1'b1);
        @(negedge clk);
`ifdef PIPE_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("rr_count", 256'(stats_count[i*32 +: 32]), 256'(2));
`endif

        // Backpressure
        cycle(1'b0, '0, '0, 1'b1, '0, 1'b0);
        cycle(1'b1, 4'b0001, 4'b0001, 1'b1, 192'h11, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 4'hF, 4'hF, 1'b0, 192'h33, 1'b0);
            @(negedge clk);
            check("bp_hold_data", 256'(pipe_data), 256'(192'h11));
            check("bp_no_grant", 256'(req_rdy), 256'(0));
        end
        cycle(1'b1, 4'b0010, 4'b0010, 1'b1, 192'h22, 1'b0);
        @(negedge clk);
        check("bp_drain_ena", 256'(pipe_ena), 256'(1));
        check("bp_drain_data", 256'(pipe_data), 256'(192'h11));
        check("bp_same_cycle_grant", 256'(req_rdy), 256'(4'b0010));
`ifdef PIPE_ARB_STATS_EN
        check("bp_stall", 256'(stats_stall), 256'(5));
`endif
        cycle(1'b1, 4'b0000, 4'b0000, 1'b1, '0, 1'b0);
        @(negedge clk);
        check("bp_next_data", 256'(pipe_data), 256'(192'h22));

        // Pointer skip: move pointer to 3, then clients 1 and 2
        cycle(1'b1, 4'b0100, 4'b0100, 1'b1, '0, 1'b1);
        @(negedge clk);
        check("skip_setup", 256'(req_rdy), 256'(4'b0100));
        cycle(1'b1, 4'b0110, 4'b0110, 1'b1, '0, 1'b1);
        @(negedge clk);
        check("skip_first", 256'(req_rdy), 256'(4'b0010));
        cycle(1'b1, 4'b0110, 4'b0110, 1'b1, '0, 1'b1);
        @(negedge clk);
        check("skip_second", 256'(req_rdy), 256'(4'b0100));

        // Granted but idle
        cycle(1'b0, '0, '0, 1'b1, '0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 4'b0001, 4'b0000, 1'b1, '0, 1'b1);
            @(negedge clk);
            check("idle_rdy", 256'(req_rdy), 256'(4'b0001));
            check("idle_no_load", 256'(pipe_ena), 256'(0));
        end
        cycle(1'b1, 4'b0011, 4'b0000, 1'b1, '0, 1'b1);
        @(negedge clk);
        check("idle_ptr_held", 256'(req_rdy), 256'(4'b0001));

        // Reset mid-stream
        cycle(1'b1, 4'b0001, 4'b0001, 1'b1, 192'h55, 1'b0);
        cycle(1'b0, 4'b0001, 4'b0001, 1'b1, '0, 1'b0);
        @(negedge clk);
        check("rst_during_ena", 256'(pipe_ena), 256'(0));
        check("rst_during_rdy", 256'(req_rdy), 256'(0));
        cycle(1'b1, 4'hF, 4'h0, 1'b1, '0, 1'b0);
        @(negedge clk);
        check("rst_after_ena", 256'(pipe_ena), 256'(0));
        check("rst_after_ptr", 256'(req_rdy), 256'(4'b0001));
        check("rst_after_count", 256'(stats_count), 256'(0));
        check("rst_after_stall", 256'(stats_stall), 256'(0));

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 199) != 0), N'($urandom), N'($urandom),
                  ($urandom_range(0, 9) < 7), '0, 1'b1);
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
